// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver
//   Queues {J,K} drive commands in a small FIFO and plays each one onto a
//   downstream JK flip-flop for (len + 1) clock cycles. Successive commands
//   are played with no idle gap. o_done pulses once per completed command.
//
// Ports
//   i_clk        single clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_cmd_valid  command present on i_cmd / i_cmd_len
//   i_cmd        {J,K}: 00 hold, 01 reset, 10 set, 11 toggle
//   i_cmd_len    drive duration minus one, in cycles
//   o_cmd_ready  FIFO can accept a command this cycle
//   o_j, o_k     registered J/K drive
//   o_busy       a command is being driven
//   o_done       one-cycle completion pulse
//   o_level      FIFO occupancy, 0..P_DEPTH
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | nothing being driven, o_j = o_k = 0, waiting for a FIFO entry
// S_DRIVE | holding o_j/o_k while the down-counter runs to terminal count
module jk_cmd_driver #(
  parameter int P_DEPTH = 4,
  parameter int P_LEN_W = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cmd_valid,
  input  logic [1:0]                 i_cmd,
  input  logic [P_LEN_W-1:0]         i_cmd_len,
  output logic                       o_cmd_ready,
  output logic                       o_j,
  output logic                       o_k,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(P_DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(P_DEPTH);
  localparam int ENT_W = 2 + P_LEN_W;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(P_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_DRIVE
  } state_e;

  logic [ENT_W-1:0]   mem_q [P_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     level_q, level_d;
  logic [P_LEN_W-1:0] cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic               j_q, j_d;
  logic               k_q, k_d;
  logic               done_q, done_d;
  logic               push;
  logic               pop;
  logic [ENT_W-1:0]   head;

  // Ready is taken from the registered level, so a pop on the same edge
  // as a full FIFO does not open a slot until the following cycle.
  assign o_cmd_ready = !i_rst && (level_q != FULL_LVL);
  assign push        = i_cmd_valid && o_cmd_ready;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (level_q != '0) begin
          pop        = 1'b1;
          {j_d, k_d} = head[ENT_W-1 -: 2];
          cnt_d      = head[P_LEN_W-1:0];
          state_d    = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          done_d = 1'b1;
          if (level_q != '0) begin
            // chain straight into the next command, no idle cycle
            pop        = 1'b1;
            {j_d, k_d} = head[ENT_W-1 -: 2];
            cnt_d      = head[P_LEN_W-1:0];
          end else begin
            j_d     = 1'b0;
            k_d     = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: an entry is only read after being written.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_cmd, i_cmd_len};
    end
  end

  assign o_j     = j_q;
  assign o_k     = k_q;
  assign o_busy  = (state_q == S_DRIVE);
  assign o_done  = done_q;
  assign o_level = level_q;

endmodule

// File: tb/tb_jk_cmd_driver.sv
module tb_jk_cmd_driver;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_cmd_valid;
  logic [1:0] i_cmd;
  logic [3:0] i_cmd_len;
  logic       o_cmd_ready;
  logic       o_j;
  logic       o_k;
  logic       o_busy;
  logic       o_done;
  logic [2:0] o_level;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] sb [$];
  bit         mon_en = 1'b0;
  bit         cur_valid = 1'b0;
  bit         prev_busy = 1'b0;
  logic [1:0] cur_code;
  logic [3:0] cur_len;
  int         run_cnt;

  jk_cmd_driver #(.P_DEPTH(4), .P_LEN_W(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd       (i_cmd),
    .i_cmd_len   (i_cmd_len),
    .o_cmd_ready (o_cmd_ready),
    .o_j         (o_j),
    .o_k         (o_k),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_level     (o_level)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] c, input logic [3:0] l);
    int n = 0;
    while (!o_cmd_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk(32'(o_cmd_ready), 32'd1, "push_ready_timeout");
    if (o_cmd_ready) begin
      i_cmd_valid = 1'b1;
      i_cmd       = c;
      i_cmd_len   = l;
      sb.push_back({c, l});
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((o_busy || o_level != 3'd0) && n < bound) begin
      @(negedge i_clk);
      n++;
    end
    chk(32'(o_busy || o_level != 3'd0), 32'd0, "drain_timeout");
    @(negedge i_clk);
    @(negedge i_clk);
  endtask

  // Scoreboard monitor: a new command starts when busy rises or when a done
  // pulse coincides with busy (back-to-back). Each run must carry the
  // queued code and last len+1 cycles.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!mon_en) begin
        cur_valid = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (o_done) begin
          chk(32'(cur_valid), 32'd1, "done_owner");
          if (cur_valid) chk(32'(run_cnt), 32'(cur_len) + 32'd1, "run_len");
          cur_valid = 1'b0;
        end
        if (o_busy && (!prev_busy || o_done)) begin
          chk(32'(sb.size() != 0), 32'd1, "sb_nonempty");
          if (sb.size() != 0) begin
            {cur_code, cur_len} = sb.pop_front();
            cur_valid = 1'b1;
            run_cnt   = 0;
          end
        end
        if (o_busy && cur_valid) begin
          chk(32'({o_j, o_k}), 32'(cur_code), "jk_code");
          run_cnt++;
        end
        if (!o_busy) chk(32'({o_j, o_k}), 32'd0, "idle_jk");
        prev_busy = o_busy;
      end
    end
  end

  initial begin
    bit         ej [6];
    bit         eb [7];
    bit         ed [7];
    logic [1:0] ejk [6];
    int         cnt_a;
    int         cnt_b;
    int         acc;
    int         n;
    int         e5;
    int         e6;
    bit         seen5;

    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd       = 2'b00;
    i_cmd_len   = 4'd0;

    // reset state
    @(negedge i_clk);
    chk(32'(o_cmd_ready), 32'd0, "rst_ready_low");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk(32'({o_j, o_k}), 32'd0, "rst_jk");
    chk(32'(o_busy), 32'd0, "rst_busy");
    chk(32'(o_done), 32'd0, "rst_done");
    chk(32'(o_level), 32'd0, "rst_level");
    chk(32'(o_cmd_ready), 32'd1, "rst_ready");
    mon_en = 1'b1;

    // single command 10/len2 pushed at edge T
    ej = '{0, 1, 1, 1, 0, 0};
    ed = '{0, 0, 0, 0, 1, 0, 0};
    i_cmd_valid = 1'b1;
    i_cmd       = 2'b10;
    i_cmd_len   = 4'd2;
    sb.push_back({2'b10, 4'd2});
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      chk(32'(o_j), 32'(ej[c]), "single_j");
      chk(32'(o_k), 32'd0, "single_k");
      chk(32'(o_busy), 32'(ej[c]), "single_busy");
      chk(32'(o_done), 32'(ed[c]), "single_done");
    end
    wait_idle(50);

    // back-to-back 11/len0 then 01/len1
    ejk = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
    ed  = '{0, 0, 1, 0, 1, 0, 0};
    cnt_a = 0;
    i_cmd_valid = 1'b1;
    i_cmd       = 2'b11;
    i_cmd_len   = 4'd0;
    sb.push_back({2'b11, 4'd0});
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (c == 0) begin
        i_cmd     = 2'b01;
        i_cmd_len = 4'd1;
        sb.push_back({2'b01, 4'd1});
      end else begin
        i_cmd_valid = 1'b0;
      end
      chk(32'({o_j, o_k}), 32'(ejk[c]), "b2b_jk");
      chk(32'(o_done), 32'(ed[c]), "b2b_done");
      if (o_done) cnt_a++;
    end
    chk(32'(cnt_a), 32'd2, "b2b_done_count");
    wait_idle(50);

    // hold command 00/len3
    eb = '{0, 1, 1, 1, 1, 0, 0};
    ed = '{0, 0, 0, 0, 0, 1, 0};
    cnt_a = 0;
    cnt_b = 0;
    i_cmd_valid = 1'b1;
    i_cmd       = 2'b00;
    i_cmd_len   = 4'd3;
    sb.push_back({2'b00, 4'd3});
    for (int c = 0; c < 7; c++) begin
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      chk(32'({o_j, o_k}), 32'd0, "hold_jk");
      chk(32'(o_busy), 32'(eb[c]), "hold_busy");
      chk(32'(o_done), 32'(ed[c]), "hold_done");
      if (o_busy) cnt_a++;
      if (o_done) cnt_b++;
    end
    chk(32'(cnt_a), 32'd4, "hold_busy_cycles");
    chk(32'(cnt_b), 32'd1, "hold_done_count");
    wait_idle(50);

    // full: valid held with six 10/len15 commands
    i_cmd_valid = 1'b1;
    i_cmd       = 2'b10;
    i_cmd_len   = 4'd15;
    acc   = 0;
    n     = 0;
    e5    = 0;
    e6    = 0;
    seen5 = 1'b0;
    while (acc < 6 && n < 60) begin
      if (o_cmd_ready) begin
        sb.push_back({2'b10, 4'd15});
        acc++;
        if (acc == 5) e5 = n;
        if (acc == 6) e6 = n;
      end
      @(negedge i_clk);
      n++;
      if (acc == 5 && !seen5) begin
        seen5 = 1'b1;
        chk(32'(o_level), 32'd4, "full_level");
        chk(32'(o_cmd_ready), 32'd0, "full_ready");
      end
    end
    i_cmd_valid = 1'b0;
    chk(32'(acc), 32'd6, "full_accepts");
    chk(32'(e6 - e5), 32'd14, "full_6th_edge");
    chk(32'(o_level), 32'd4, "full_level_after_6th");
    wait_idle(200);

    // wrap-around: ten len0 commands with cycling codes
    for (int i = 0; i < 10; i++) begin
      push_cmd(2'((i + 1) % 4), 4'd0);
    end
    wait_idle(100);
    chk(32'(o_level), 32'd0, "wrap_level");
    chk(32'(sb.size()), 32'd0, "wrap_sb_empty");

    // reset during an active 11 command with level 3
    for (int i = 0; i < 4; i++) begin
      push_cmd(2'b11, 4'd15);
    end
    chk(32'(o_level), 32'd3, "prerst_level");
    chk(32'(o_busy), 32'd1, "prerst_busy");
    chk(32'({o_j, o_k}), 32'd3, "prerst_jk");
    mon_en = 1'b0;
    sb.delete();
    i_rst = 1'b1;
    @(negedge i_clk);
    chk(32'(o_cmd_ready), 32'd0, "midrst_ready_low");
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk(32'({o_j, o_k}), 32'd0, "postrst_jk");
    chk(32'(o_level), 32'd0, "postrst_level");
    chk(32'(o_busy), 32'd0, "postrst_busy");
    chk(32'(o_done), 32'd0, "postrst_done");
    chk(32'(o_cmd_ready), 32'd1, "postrst_ready");
    mon_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      chk(32'(o_done), 32'd0, "flush_no_done");
      chk(32'(o_busy), 32'd0, "flush_no_busy");
    end

    // a command after the flush still works
    push_cmd(2'b01, 4'd1);
    wait_idle(50);
    chk(32'(sb.size()), 32'd0, "final_sb_empty");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
